data_memory_byte_writer: RTL and testbench
==========================================

// Module: data_memory_byte_writer
// PURPOSE
//  Upstream loader for the 4096x32 single-port data memory. Accepts a byte stream (valid/ready)
//  from the host/cipher side and packs it little-endian into 32-bit words. Writes the words
//  sequentially from a programmed word base address, using byteenables for a partial final word.
//  Reports completion with a one-cycle done pulse. No read path; the memory is write-only from this block.
// PARAMETERS
//  ADDR_W   12   memory word-address width (4096 words)
//  LEN_W    15   byte-count width (max 16384 bytes = full memory)
// PORTS
//  clk             in   1       single clock
//  reset           in   1       asynchronous, active-high reset
//  cfg_start       in   1       start pulse; sampled only in IDLE
//  cfg_base_addr   in   ADDR_W  first word address, latched on start
//  cfg_byte_len    in   LEN_W   bytes to transfer, latched on start (0 legal)
//  s_data          in   8       stream byte
//  s_valid         in   1       s_data valid
//  s_ready         out  1       byte accepted when s_valid&s_ready
//  mem_chipselect  out  1       memory select (high only with mem_write)
//  mem_write       out  1       single-cycle write strobe; memory has no waitrequest
//  mem_address     out  ADDR_W  word address
//  mem_byteenable  out  4       lane enables, bit k = writedata[8k+7:8k]
//  mem_writedata   out  32      packed word; unfilled lanes driven 0
//  mem_clken       out  1       tied 1
//  busy            out  1       transfer in progress
//  done            out  1       one-cycle completion pulse
//  err_wrap        out  1       sticky: address wrapped past 4095; cleared on next accepted start
// BEHAVIOUR
//  Reset: FSM=IDLE. s_ready, mem_chipselect, mem_write, busy, done and err_wrap are 0.
//   mem_address, mem_byteenable and mem_writedata are 0. Accumulator, lane index and counters are 0.
//  FSM: IDLE -> ACTIVE on cfg_start with len>0. IDLE -> DONE on cfg_start with len==0.
//   ACTIVE -> DRAIN when the last byte is accepted. DRAIN -> DONE once the final write has issued.
//   DONE -> IDLE unconditionally (1 cycle).
//  busy=1 in ACTIVE/DRAIN; done=1 only in DONE; busy=0 in DONE.
//  cfg_start outside IDLE: ignored, no effect on latched config.
//  s_ready=1 only in ACTIVE. This gives 1 byte/cycle sustained throughput; no stalls from memory writes.
//  Packing: the n-th accepted byte (from 0) goes to lane n mod 4 of the word at base + n/4.
//   The word is complete when lane 3 is filled or the byte is the last of the transfer.
//  Write timing: completing byte accepted in cycle T -> cycle T+1: mem_write=mem_chipselect=1 with
//   address/data/byteenable of that word. The accumulator is cleared at T+1, so a byte accepted at T+1
//   starts the next word with no bubble.
//  byteenable: 4'b1111 for full words. A partial last word is contiguous from lane 0:
//   1 byte->0001, 2->0011, 3->0111.
//  Last byte accepted at T: final write at T+1 (in DRAIN), done at T+2, s_ready=0 from T+1.
//  len==0: start at T -> done at T+1, no memory write.
//  Address arithmetic modulo 2^ADDR_W. An increment 4095->0 sets err_wrap; the transfer continues.
//  Bytes with s_valid=0 are never counted; s_data is don't-care then.
//  Reset mid-transfer: abort immediately. No partial-word flush, no done pulse, mem_write forced 0.
// STRUCTURE
//  Shared package tedv3_mem_pkg:
//   - state enum {IDLE, ACTIVE, DRAIN, DONE}
//   - BYTES_PER_WORD=4, MEM_ADDR_W=12, MEM_LEN_W=15
//   - function be_for_count(count[1:0]) -> byteenable
//  Sub-module byte_lane_packer: lane index, 32-bit accumulator, lane-valid mask, word_complete flag.
//  Top level: FSM, byte/word counters, registered memory-side outputs.
// TESTING
//  1 base=0x010, len=8, bytes 01..08 back-to-back -> writes at T+1 of bytes 4 and 8:
//    @0x010 data=0x04030201 be=1111; @0x011 data=0x08070605 be=1111; then done one cycle, err_wrap=0.
//  2 base=0x020, len=6, bytes AA..AF -> @0x020 0xADACABAA be=1111;
//    @0x021 0x0000AFAE be=0011; done 2 cycles after last accept.
//  3 len=0 start -> done exactly 1 cycle later, no mem_write ever, busy never 1.
//  4 base=0xFFF, len=8 -> writes @0xFFF then @0x000, err_wrap=1 after 2nd word; next start clears it.
//  5 len=5 with s_valid gaps (random 0-3 idle cycles) and cfg_start pulsed while busy ->
//    same memory image as gapless run; config unchanged.
//  6 assert reset mid-word (2 of 4 bytes taken) -> no write that word, outputs at reset values;
//    a fresh start then operates normally.

Source files
------------

// File: rtl/tedv3_mem_pkg.sv
// Shared types and helpers for the data-memory byte loader.
// Holds the FSM encoding, memory geometry and the partial-word byteenable map.
package tedv3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int MEM_ADDR_W     = 12;
  localparam int MEM_LEN_W      = 15;

  // count is the number of filled lanes modulo 4, so 0 means a full word
  function automatic logic [3:0] be_for_count(input logic [1:0] count);
    logic [3:0] be;
    case (count)
      2'd1:    be = 4'b0001;
      2'd2:    be = 4'b0011;
      2'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and flags word completion.
// The completed word is presented combinationally; the accumulator clears on the following edge.
module byte_lane_packer
  import tedv3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic        last_i,
  input  logic [7:0]  data_i,
  output logic        word_complete_o,
  output logic [31:0] word_o,
  output logic [3:0]  lane_mask_o
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       merged;

  always_comb begin
    merged          = acc_q | ({24'b0, data_i} << {lane_q, 3'b000});
    word_complete_o = accept_i & ((lane_q == LAST_LANE) | last_i);
    word_o          = merged;
    lane_mask_o     = be_for_count(lane_q + LANE_W'(1));
    lane_d          = lane_q;
    acc_d           = acc_q;
    if (word_complete_o) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (accept_i) begin
      lane_d = lane_q + LANE_W'(1);
      acc_d  = merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/data_memory_byte_writer.sv
// Streams bytes into the 4096x32 data memory as packed little-endian words from a base address.
// One byte per cycle while ACTIVE; the write for a word issues the cycle after its completing byte.
module data_memory_byte_writer
  import tedv3_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_byte_len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              err_wrap
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_data_q, mem_data_d;

  logic        accept;
  logic        last_byte;
  logic        word_complete;
  logic [31:0] word;
  logic [3:0]  lane_mask;

  assign accept    = s_valid & (state_q == ACTIVE);
  assign last_byte = (cnt_q == len_q - LEN_W'(1));

  byte_lane_packer u_packer (
    .clk             (clk),
    .reset           (reset),
    .accept_i        (accept),
    .last_i          (last_byte),
    .data_i          (s_data),
    .word_complete_o (word_complete),
    .word_o          (word),
    .lane_mask_o     (lane_mask)
  );

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_data_d  = mem_data_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          word_addr_d = cfg_base_addr;
          len_d       = cfg_byte_len;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = (cfg_byte_len == '0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_byte) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    // The address only advances when another word follows, so err_wrap means data really wrapped
    if (word_complete) begin
      mem_write_d = 1'b1;
      mem_addr_d  = word_addr_q;
      mem_data_d  = word;
      mem_be_d    = lane_mask;
      if (!last_byte) begin
        word_addr_d = word_addr_q + ADDR_W'(1);
        if (&word_addr_q) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign s_ready        = (state_q == ACTIVE);
  assign mem_write      = mem_write_q;
  assign mem_chipselect = mem_write_q;
  assign mem_address    = mem_addr_q;
  assign mem_byteenable = mem_be_q;
  assign mem_writedata  = mem_data_q;
  assign mem_clken      = 1'b1;
  assign busy           = (state_q == ACTIVE) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign err_wrap       = err_q;

endmodule

// File: tb/tb_data_memory_byte_writer.sv
// Directed bench for data_memory_byte_writer: vector table of transfers plus
// hand-written zero-length and mid-word reset sequences.
module tb_data_memory_byte_writer;

  logic        clk;
  logic        reset;
  logic        cfg_start;
  logic [11:0] cfg_base_addr;
  logic [14:0] cfg_byte_len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_chipselect;
  logic        mem_write;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        busy;
  logic        done;
  logic        err_wrap;

  data_memory_byte_writer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_byte_len   (cfg_byte_len),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .done           (done),
    .err_wrap       (err_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        cs;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  busy_cnt = 0;
  logic done_busy = 1'b0;

  always @(negedge clk) begin
    if (mem_write) wq.push_back('{mem_address, mem_writedata, mem_byteenable, mem_chipselect, cyc});
    if (done) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int acc_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_start(input logic [11:0] base, input logic [14:0] len, output int st);
    @(negedge clk);
    cfg_start     = 1'b1;
    cfg_base_addr = base;
    cfg_byte_len  = len;
    st            = cyc;
    @(negedge clk);
    cfg_start     = 1'b0;
  endtask

  // Called on a negedge; a byte presented while s_ready is high is taken at the next posedge.
  task automatic stream(input int n, input logic [7:0] first, input int maxgap, input logic poke);
    for (int i = 0; i < n; i++) begin
      int g;
      int tmo;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = first + 8'(i);
      if (poke && i == 2) begin
        cfg_start     = 1'b1;
        cfg_base_addr = 12'hABC;
        cfg_byte_len  = 15'd3;
      end
      tmo = 0;
      while (!s_ready && tmo < 20) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 20) begin
        chk("ready_timeout", 32'd1, 32'd0);
        s_valid   = 1'b0;
        cfg_start = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      @(negedge clk);
      cfg_start = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  typedef struct {
    logic [11:0] base;
    logic [14:0] len;
    logic [7:0]  first;
    int          gap;
    logic        poke;
    int          nw;
    logic [11:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic [11:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
    logic        err;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int wb, db, st, got, idx, lastb;
    logic [11:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    wb = wq.size();
    db = done_cnt;
    acc_cyc.delete();
    do_start(v.base, v.len, st);
    chk({tag, "_err_cleared"}, {31'b0, err_wrap}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    stream(int'(v.len), v.first, v.gap, v.poke);
    for (int t = 0; t < 30 && done_cnt == db; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    got = wq.size() - wb;
    chk({tag, "_nwords"}, got, v.nw);
    for (int k = 0; k < v.nw && k < got; k++) begin
      ea = (k == 0) ? v.a0 : v.a1;
      ed = (k == 0) ? v.d0 : v.d1;
      eb = (k == 0) ? v.b0 : v.b1;
      chk({tag, "_addr"}, {20'b0, wq[wb+k].a}, {20'b0, ea});
      chk({tag, "_data"}, wq[wb+k].d, ed);
      chk({tag, "_be"}, {28'b0, wq[wb+k].be}, {28'b0, eb});
      chk({tag, "_cs"}, {31'b0, wq[wb+k].cs}, 32'd1);
      idx = (4*k + 3 < int'(v.len)) ? 4*k + 3 : int'(v.len) - 1;
      if (idx < acc_cyc.size()) chk({tag, "_wr_cycle"}, wq[wb+k].cyc, acc_cyc[idx] + 1);
    end
    lastb = acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -100;
    chk({tag, "_done_cycle"}, done_cyc, lastb + 2);
    chk({tag, "_done_pulses"}, done_cnt - db, 32'd1);
    chk({tag, "_busy_in_done"}, {31'b0, done_busy}, 32'd0);
    chk({tag, "_err_wrap"}, {31'b0, err_wrap}, {31'b0, v.err});
    chk({tag, "_ready_idle"}, {31'b0, s_ready}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
    chk({tag, "_write"}, {30'b0, mem_write, mem_chipselect}, 32'd0);
    chk({tag, "_addr"}, {20'b0, mem_address}, 32'd0);
    chk({tag, "_be"}, {28'b0, mem_byteenable}, 32'd0);
    chk({tag, "_data"}, mem_writedata, 32'd0);
    chk({tag, "_busy_done_err"}, {29'b0, busy, done, err_wrap}, 32'd0);
    chk({tag, "_clken"}, {31'b0, mem_clken}, 32'd1);
  endtask

  vec_t vt[5];
  vec_t post;

  initial begin
    int st, wb, db, bb;
    vt[0] = '{12'h010, 15'd8, 8'h01, 0, 1'b0, 2, 12'h010, 32'h04030201, 4'b1111, 12'h011, 32'h08070605, 4'b1111, 1'b0};
    vt[1] = '{12'h020, 15'd6, 8'hAA, 0, 1'b0, 2, 12'h020, 32'hADACABAA, 4'b1111, 12'h021, 32'h0000AFAE, 4'b0011, 1'b0};
    vt[2] = '{12'hFFF, 15'd8, 8'h10, 0, 1'b0, 2, 12'hFFF, 32'h13121110, 4'b1111, 12'h000, 32'h17161514, 4'b1111, 1'b1};
    vt[3] = '{12'h100, 15'd5, 8'h30, 3, 1'b1, 2, 12'h100, 32'h33323130, 4'b1111, 12'h101, 32'h00000034, 4'b0001, 1'b0};
    vt[4] = '{12'h7FE, 15'd3, 8'h55, 0, 1'b0, 1, 12'h7FE, 32'h00575655, 4'b0111, 12'h000, 32'h0, 4'b0000, 1'b0};
    post  = '{12'h040, 15'd4, 8'hC0, 0, 1'b0, 1, 12'h040, 32'hC3C2C1C0, 4'b1111, 12'h000, 32'h0, 4'b0000, 1'b0};

    reset         = 1'b1;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_byte_len  = '0;
    s_data        = '0;
    s_valid       = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("idle");

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // zero-length transfer: done the cycle after start, nothing written, never busy
    wb = wq.size();
    db = done_cnt;
    bb = busy_cnt;
    do_start(12'h123, 15'd0, st);
    repeat (3) @(negedge clk);
    chk("len0_done_cycle", done_cyc, st + 1);
    chk("len0_done_pulses", done_cnt - db, 32'd1);
    chk("len0_no_write", wq.size() - wb, 32'd0);
    chk("len0_never_busy", busy_cnt - bb, 32'd0);

    // reset with two of four lanes filled: no flush, no done
    wb = wq.size();
    db = done_cnt;
    acc_cyc.delete();
    do_start(12'h200, 15'd8, st);
    stream(2, 8'h60, 0, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_write", wq.size() - wb, 32'd0);
    chk("midrst_no_done", done_cnt - db, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_vec(post, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
